// File: rtl/passcode_lockout_fsm_pkg.sv
// passcode_lockout_fsm_pkg
// Shared definitions for the passcode gate: the FSM state encoding, the
// digit width and the helper that picks one digit out of the packed code.
package passcode_lockout_fsm_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    // Digit idx of an attempt. The most-significant used nibble is entered
    // first, so digit 0 lives at nibble position code_len-1.
    function automatic logic [DIGIT_W-1:0] code_nibble(
        input logic [31:0] code,
        input int          code_len,
        input logic [2:0]  idx
    );
        logic [31:0] shifted;
        int          pos;
        pos     = code_len - 1 - int'(idx);
        shifted = code >> (DIGIT_W * pos);
        return shifted[DIGIT_W-1:0];
    endfunction

endpackage

// File: rtl/passcode_lockout_fsm_if.sv
// passcode_lockout_fsm_if
// Bundles the keypad side (enter pulse + digit) and the status/enable side
// of the passcode gate.
//   master : drives enter/digit, observes status (keypad / bench side)
//   slave  : the gate itself
// Handshake: enter is a one-cycle valid pulse with no ready; digit is only
// meaningful in a cycle where enter is high. Pulses the gate cannot accept
// (CHECK, LOCKOUT, UNLOCKED) are dropped, never stalled or queued.
// state_dbg exposes the FSM state for observation only.
interface passcode_lockout_fsm_if;
    import passcode_lockout_fsm_pkg::*;

    logic                enter;
    logic [DIGIT_W-1:0]  digit;
    logic                adderEnable;
    logic                adderDisable;
    logic                lockedOut;
    logic                failPulse;
    logic [2:0]          triesLeft;
    logic [2:0]          digitCount;
    state_t              state_dbg;

    modport master (
        output enter, digit,
        input  adderEnable, adderDisable, lockedOut, failPulse,
               triesLeft, digitCount, state_dbg
    );

    modport slave (
        input  enter, digit,
        output adderEnable, adderDisable, lockedOut, failPulse,
               triesLeft, digitCount, state_dbg
    );

endinterface

// File: rtl/passcode_lockout_fsm_lockout_timer.sv
// lockout_timer
// Loadable down-counter that times the lockout period.
//   clk, rts  : clock, synchronous active-high reset
//   load      : start a new countdown from load_val
//   load_val  : first count value (LOCK_CYCLES-1 for a LOCK_CYCLES period)
//   busy      : countdown in progress
//   done      : high in the cycle the count sits at zero while busy
module lockout_timer #(
    parameter int LOCK_CYCLES = 1000,
    parameter int TW          = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          rts,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          busy,
    output logic          done
);

    logic [TW-1:0] count_q, count_d;
    logic          busy_q,  busy_d;

    always_comb begin
        count_d = count_q;
        busy_d  = busy_q;
        if (load) begin
            count_d = load_val;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (count_q == '0) begin
                busy_d = 1'b0;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rts) begin
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (count_q == '0);

endmodule

// File: rtl/passcode_lockout_fsm.sv
// passcode_lockout_fsm
// Multi-digit passcode gate in front of the adder operand registers.
// Collects CODE_LEN digits, flags any wrong digit, and after the last one
// either unlocks (terminal until reset) or counts a failed try. Running out
// of tries starts a LOCK_CYCLES lockout, after which the tries are refilled.
//   clk, rts : clock, synchronous active-high reset (wins over everything)
//   bus      : slave side of passcode_lockout_fsm_if (enter/digit in,
//              enable/disable pair, lockedOut, failPulse, counters out)
module passcode_lockout_fsm
    import passcode_lockout_fsm_pkg::*;
#(
    parameter int          CODE_LEN    = 4,
    parameter logic [31:0] CODE        = 32'h0000_5293,
    parameter int          MAX_TRIES   = 3,
    parameter int          LOCK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rts,
    passcode_lockout_fsm_if.slave bus
);

    localparam int            TW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(LOCK_CYCLES - 1);
    localparam logic [2:0]    TRIES_INIT = 3'(MAX_TRIES);

    state_t     state_q,    state_d;
    logic [2:0] dcnt_q,     dcnt_d;
    logic       mismatch_q, mismatch_d;
    logic [2:0] tries_q,    tries_d;
    logic       en_q,       en_d;
    logic       dis_q,      dis_d;
    logic       fail_q,     fail_d;
    logic       lock_q,     lock_d;

    logic       timer_load;
    logic       timer_busy;
    logic       timer_done;
    logic [3:0] dcnt_next;   // one bit wider so CODE_LEN = 8 compares cleanly

    lockout_timer #(
        .LOCK_CYCLES (LOCK_CYCLES),
        .TW          (TW)
    ) u_timer (
        .clk      (clk),
        .rts      (rts),
        .load     (timer_load),
        .load_val (LOAD_VAL),
        .busy     (timer_busy),
        .done     (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        mismatch_d = mismatch_q;
        tries_d    = tries_q;
        fail_d     = 1'b0;
        timer_load = 1'b0;
        dcnt_next  = {1'b0, dcnt_q} + 4'd1;

        case (state_q)
            ENTRY: begin
                if (bus.enter) begin
                    // Sticky: one wrong digit poisons the whole attempt.
                    mismatch_d = mismatch_q |
                                 (bus.digit != code_nibble(CODE, CODE_LEN, dcnt_q));
                    dcnt_d     = dcnt_next[2:0];
                    if (dcnt_next == 4'(CODE_LEN)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                dcnt_d     = '0;
                mismatch_d = 1'b0;
                if (!mismatch_q) begin
                    state_d = UNLOCKED;
                end else begin
                    fail_d  = 1'b1;
                    tries_d = (tries_q == '0) ? '0 : tries_q - 3'd1;
                    if (tries_d == '0) begin
                        state_d    = LOCKOUT;
                        timer_load = 1'b1;
                    end else begin
                        state_d = ENTRY;
                    end
                end
            end
            UNLOCKED: begin
                // Terminal; enters belong to the downstream registers now.
            end
            LOCKOUT: begin
                // !timer_busy guards against ever sitting here with an idle timer.
                if (timer_done || !timer_busy) begin
                    state_d = ENTRY;
                    tries_d = TRIES_INIT;
                end
            end
            default: begin
                state_d = ENTRY;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        en_d   = (state_d == UNLOCKED);
        dis_d  = (state_d != UNLOCKED);
        lock_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (rts) begin
            state_q    <= ENTRY;
            dcnt_q     <= '0;
            mismatch_q <= 1'b0;
            tries_q    <= TRIES_INIT;
            en_q       <= 1'b0;
            dis_q      <= 1'b1;
            fail_q     <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            mismatch_q <= mismatch_d;
            tries_q    <= tries_d;
            en_q       <= en_d;
            dis_q      <= dis_d;
            fail_q     <= fail_d;
            lock_q     <= lock_d;
        end
    end

    assign bus.adderEnable  = en_q;
    assign bus.adderDisable = dis_q;
    assign bus.lockedOut    = lock_q;
    assign bus.failPulse    = fail_q;
    assign bus.triesLeft    = tries_q;
    assign bus.digitCount   = dcnt_q;
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_passcode_lockout_fsm.sv
module tb_passcode_lockout_fsm;
    import passcode_lockout_fsm_pkg::*;

    localparam int          LOCK  = 16;
    localparam int          MAXT  = 3;
    localparam logic [15:0] GOOD  = 16'h5293;

    logic clk = 1'b0;
    logic rts;
    always #5 clk = ~clk;

    passcode_lockout_fsm_if bus ();

    passcode_lockout_fsm #(
        .CODE_LEN    (4),
        .CODE        (32'h0000_5293),
        .MAX_TRIES   (MAXT),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .clk (clk),
        .rts (rts),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int fail_seen = 0;
    int pair_bad = 0;
    bit mon_en = 1'b0;

    // Reference model: tries remaining and whether the gate has opened.
    int m_tries;
    bit m_unlocked;
    logic [2:0] exp_q[$];   // expected triesLeft after each rejected attempt

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.failPulse === 1'b1) fail_seen++;
            if (bus.adderEnable === bus.adderDisable) pair_bad++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rts       = 1'b1;
        bus.enter = 1'b0;
        bus.digit = 4'd0;
        tick();
        rts        = 1'b0;
        m_tries    = MAXT;
        m_unlocked = 1'b0;
        mon_en     = 1'b1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.enter = 1'b1;
        bus.digit = d;
        tick();
        bus.enter = 1'b0;
    endtask

    // One full attempt of four digits (most significant first), then the
    // outcome is checked one edge after the CHECK cycle.
    task automatic attempt(input logic [15:0] w, input bit gaps, input string name);
        bit ok;
        ok = (w == GOOD);
        for (int i = 0; i < 4; i++) begin
            press(w[15-4*i -: 4]);
            if (gaps && i < 3) repeat ($urandom_range(0, 2)) tick();
        end
        checks++;
        if (bus.adderEnable !== 1'b0) begin
            errors++;
            $display("FAIL %s_check_cycle_en: got %b want 0", name, bus.adderEnable);
        end
        tick();
        if (ok) begin
            m_unlocked = 1'b1;
            checks++;
            if (bus.adderEnable !== 1'b1 || bus.adderDisable !== 1'b0) begin
                errors++;
                $display("FAIL %s_unlock: en=%b dis=%b want 1/0", name, bus.adderEnable, bus.adderDisable);
            end
            checks++;
            if (bus.failPulse !== 1'b0 || bus.triesLeft !== 3'(m_tries)) begin
                errors++;
                $display("FAIL %s_unlock_status: fail=%b tries=%0d want 0/%0d",
                         name, bus.failPulse, bus.triesLeft, m_tries);
            end
        end else begin
            logic [2:0] et;
            m_tries = (m_tries > 0) ? m_tries - 1 : 0;
            exp_q.push_back(3'(m_tries));
            et = exp_q.pop_front();
            checks++;
            if (bus.failPulse !== 1'b1 || bus.adderEnable !== 1'b0) begin
                errors++;
                $display("FAIL %s_reject: fail=%b en=%b want 1/0", name, bus.failPulse, bus.adderEnable);
            end
            checks++;
            if (bus.triesLeft !== et || bus.digitCount !== 3'd0) begin
                errors++;
                $display("FAIL %s_reject_counts: tries=%0d dc=%0d want %0d/0",
                         name, bus.triesLeft, bus.digitCount, et);
            end
            checks++;
            if (bus.lockedOut !== (m_tries == 0)) begin
                errors++;
                $display("FAIL %s_reject_lock: got %b want %b", name, bus.lockedOut, (m_tries == 0));
            end
        end
    endtask

    // Called right after the rejecting edge: counts lockedOut cycles, optionally
    // typing the correct code starting at cycle inject_at.
    task automatic wait_lockout(input int inject_at, input string name);
        int n;
        int dis_bad;
        n = 1;
        dis_bad = 0;
        while (bus.lockedOut === 1'b1 && n < 200) begin
            if (n >= inject_at && n < inject_at + 4) begin
                bus.enter = 1'b1;
                bus.digit = GOOD[15-4*(n-inject_at) -: 4];
            end else begin
                bus.enter = 1'b0;
            end
            if (bus.adderDisable !== 1'b1 || bus.digitCount !== 3'd0) dis_bad++;
            tick();
            if (bus.lockedOut === 1'b1) n++;
        end
        bus.enter = 1'b0;
        m_tries = MAXT;
        checks++;
        if (n != LOCK) begin
            errors++;
            $display("FAIL %s_lock_len: got %0d cycles want %0d", name, n, LOCK);
        end
        checks++;
        if (dis_bad != 0) begin
            errors++;
            $display("FAIL %s_lock_dis: %0d bad cycles want 0", name, dis_bad);
        end
        checks++;
        if (bus.triesLeft !== 3'(MAXT) || bus.digitCount !== 3'd0 || bus.adderEnable !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_lock: tries=%0d dc=%0d en=%b want %0d/0/0",
                     name, bus.triesLeft, bus.digitCount, bus.adderEnable, MAXT);
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (bus.adderEnable !== 1'b0 || bus.adderDisable !== 1'b1) begin
            errors++;
            $display("FAIL %s_en_dis: en=%b dis=%b want 0/1", name, bus.adderEnable, bus.adderDisable);
        end
        checks++;
        if (bus.lockedOut !== 1'b0 || bus.failPulse !== 1'b0) begin
            errors++;
            $display("FAIL %s_lock_fail: lock=%b fail=%b want 0/0", name, bus.lockedOut, bus.failPulse);
        end
        checks++;
        if (bus.triesLeft !== 3'(MAXT) || bus.digitCount !== 3'd0) begin
            errors++;
            $display("FAIL %s_counts: tries=%0d dc=%0d want %0d/0", name, bus.triesLeft, bus.digitCount, MAXT);
        end
        checks++;
        if (bus.state_dbg !== ENTRY) begin
            errors++;
            $display("FAIL %s_state: got %0d want ENTRY", name, bus.state_dbg);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_vals("reset");
    endtask

    task automatic test_unlock();
        int f0;
        do_reset();
        f0 = fail_seen;
        attempt(GOOD, 1'b0, "unlock");
        checks++;
        if (fail_seen != f0) begin
            errors++;
            $display("FAIL unlock_no_fail: pulses=%0d want 0", fail_seen - f0);
        end
    endtask

    task automatic test_wrong_then_right();
        do_reset();
        attempt(16'h5294, 1'b0, "wrong1");
        tick();
        checks++;
        if (bus.failPulse !== 1'b0) begin
            errors++;
            $display("FAIL wrong1_pulse_width: fail=%b want 0", bus.failPulse);
        end
        attempt(GOOD, 1'b0, "right_after_wrong");
    endtask

    task automatic test_sticky();
        do_reset();
        attempt(16'h0293, 1'b0, "sticky");
    endtask

    task automatic test_lockout();
        do_reset();
        for (int i = 0; i < MAXT; i++) attempt(16'h1111, 1'b0, "lock_wrong");
        wait_lockout(3, "lockout");
        attempt(GOOD, 1'b0, "after_lockout");
    endtask

    task automatic test_reset_priority();
        do_reset();
        for (int i = 0; i < MAXT; i++) attempt(16'h1111, 1'b0, "prio_wrong");
        repeat (4) tick();
        rts = 1'b1;
        tick();
        rts = 1'b0;
        m_tries = MAXT;
        check_reset_vals("rts_mid_lock");
        press(4'd5);
        press(4'd2);
        press(4'd9);
        bus.enter = 1'b1;
        bus.digit = 4'd3;
        rts = 1'b1;
        tick();
        rts = 1'b0;
        bus.enter = 1'b0;
        check_reset_vals("rts_with_enter");
        repeat (3) tick();
        checks++;
        if (bus.adderEnable !== 1'b0 || bus.digitCount !== 3'd0) begin
            errors++;
            $display("FAIL rts_with_enter_later: en=%b dc=%0d want 0/0", bus.adderEnable, bus.digitCount);
        end
    endtask

    task automatic test_unlocked_ignores();
        int f0;
        do_reset();
        attempt(GOOD, 1'b0, "ign_unlock");
        f0 = fail_seen;
        for (int i = 0; i < 20; i++) begin
            bus.enter = 1'($urandom_range(0, 1));
            bus.digit = 4'($urandom);
            tick();
            checks++;
            if (bus.adderEnable !== 1'b1 || bus.digitCount !== 3'd0) begin
                errors++;
                $display("FAIL unlocked_ignore: en=%b dc=%0d want 1/0", bus.adderEnable, bus.digitCount);
            end
        end
        bus.enter = 1'b0;
        checks++;
        if (fail_seen != f0) begin
            errors++;
            $display("FAIL unlocked_no_fail: pulses=%0d want 0", fail_seen - f0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int a = 0; a < 30; a++) begin
            logic [15:0] w;
            w = GOOD;
            if ($urandom_range(0, 3) != 0) begin
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, 1) == 1) w[15-4*i -: 4] = 4'($urandom);
            end
            attempt(w, 1'b1, "random");
            if (m_unlocked) begin
                do_reset();
            end else if (m_tries == 0) begin
                wait_lockout(int'($urandom_range(2, 10)), "random_lock");
            end else begin
                repeat ($urandom_range(0, 2)) tick();
            end
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (pair_bad != 0) begin
            errors++;
            $display("FAIL en_dis_complement: %0d bad cycles want 0", pair_bad);
        end
    endtask

    initial begin
        rts = 1'b1;
        bus.enter = 1'b0;
        bus.digit = 4'd0;
        repeat (2) tick();
        test_reset();
        test_unlock();
        test_wrong_then_right();
        test_sticky();
        test_lockout();
        test_reset_priority();
        test_unlocked_ignores();
        test_random();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
